// File: rtl/mem_stage_lsu_if.sv
// Bundle of MEM-stage request, data-cache port and writeback-facing signals.
// The slave modport is the load/store unit. The master modport is the pipeline and cache side.
interface mem_stage_lsu_if;
    logic        req_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;

    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;

    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        fault;
    logic [1:0]  fault_cause;

    modport slave (
        input  req_valid, mem_read, mem_write, funct3, addr, store_data,
        input  dmem_resp, dmem_rdata,
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        output stall, done, load_data, fault, fault_cause
    );

    modport master (
        output req_valid, mem_read, mem_write, funct3, addr, store_data,
        output dmem_resp, dmem_rdata,
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        input  stall, done, load_data, fault, fault_cause
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit for the rv32i pipeline.
// It accepts one access in IDLE and drives the data cache from registers while in ACCESS.
// It reports completion or a fault with a one-cycle done pulse in DONE.
// Bad requests (illegal, misaligned, undefined width) never touch the cache.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_stage_lsu_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL   = 2'b11;

    // The counter only needs to reach TIMEOUT_CYCLES-1. Reaching that value means the limit is hit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    // Classify a request. Undefined widths take priority over alignment.
    function automatic logic [1:0] decode_cause(input logic mr, input logic mw,
                                                input logic [2:0] f3, input logic [1:0] off);
        logic [1:0] c;
        c = CAUSE_NONE;
        if (mr && mw) begin
            c = CAUSE_ILLEGAL;
        end else if (mr) begin
            case (f3)
                3'b000, 3'b100: c = CAUSE_NONE;
                3'b001, 3'b101: c = off[0] ? CAUSE_MISALIGN : CAUSE_NONE;
                3'b010:         c = (off != 2'b00) ? CAUSE_MISALIGN : CAUSE_NONE;
                default:        c = CAUSE_ILLEGAL;
            endcase
        end else begin
            case (f3)
                3'b000:  c = CAUSE_NONE;
                3'b001:  c = off[0] ? CAUSE_MISALIGN : CAUSE_NONE;
                3'b010:  c = (off != 2'b00) ? CAUSE_MISALIGN : CAUSE_NONE;
                default: c = CAUSE_ILLEGAL;
            endcase
        end
        return c;
    endfunction

    // Select the store lanes. Loads always fetch the full word.
    function automatic logic [3:0] lane_mask(input logic mw, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [3:0] m;
        m = 4'b1111;
        if (mw) begin
            case (f3[1:0])
                2'b00:   m = 4'b0001 << off;
                2'b01:   m = 4'b0011 << off;
                default: m = 4'b1111;
            endcase
        end else begin
            m = 4'b1111;
        end
        return m;
    endfunction

    // Move store data into its byte lanes.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] data);
        logic [31:0] d;
        case (f3[1:0])
            2'b10:   d = data;
            default: d = data << {off, 3'b000};
        endcase
        return d;
    endfunction

    // Extract the addressed lane from the cache word, then sign- or zero-extend it.
    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] w;
        logic [31:0] r;
        w = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{w[7]}}, w[7:0]};
            3'b100:  r = {24'd0, w[7:0]};
            3'b001:  r = {{16{w[15]}}, w[15:0]};
            3'b101:  r = {16'd0, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [2:0]       funct3_r;
    logic [1:0]       offset_r;
    logic             dmem_read_r;
    logic             dmem_write_r;
    logic [31:0]      dmem_address_r;
    logic [31:0]      dmem_wdata_r;
    logic [3:0]       dmem_byte_enable_r;
    logic             done_r;
    logic [31:0]      load_data_r;
    logic             fault_r;
    logic [1:0]       fault_cause_r;

    logic             req_s;
    logic [1:0]       cause_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;

    // Decode the incoming request fields in the acceptance cycle.
    always_comb begin
        req_s   = bus.req_valid & (bus.mem_read | bus.mem_write);
        cause_s = decode_cause(bus.mem_read, bus.mem_write, bus.funct3, bus.addr[1:0]);
        be_s    = lane_mask(bus.mem_write, bus.funct3, bus.addr[1:0]);
        wdata_s = bus.mem_write ? lane_wdata(bus.funct3, bus.addr[1:0], bus.store_data) : 32'd0;
    end

    // Access sequencer: accepts, drives the cache, times out, and reports completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= IDLE;
            count_r            <= '0;
            funct3_r           <= 3'd0;
            offset_r           <= 2'd0;
            dmem_read_r        <= 1'b0;
            dmem_write_r       <= 1'b0;
            dmem_address_r     <= 32'd0;
            dmem_wdata_r       <= 32'd0;
            dmem_byte_enable_r <= 4'd0;
            done_r             <= 1'b0;
            load_data_r        <= 32'd0;
            fault_r            <= 1'b0;
            fault_cause_r      <= CAUSE_NONE;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r        <= 1'b0;
                    fault_r       <= 1'b0;
                    fault_cause_r <= CAUSE_NONE;
                    count_r       <= '0;
                    if (req_s) begin
                        funct3_r <= bus.funct3;
                        offset_r <= bus.addr[1:0];
                        if (cause_s != CAUSE_NONE) begin
                            state_r       <= DONE;
                            done_r        <= 1'b1;
                            fault_r       <= 1'b1;
                            fault_cause_r <= cause_s;
                        end else begin
                            state_r            <= ACCESS;
                            dmem_read_r        <= bus.mem_read;
                            dmem_write_r       <= bus.mem_write;
                            dmem_address_r     <= {bus.addr[31:2], 2'b00};
                            dmem_wdata_r       <= wdata_s;
                            dmem_byte_enable_r <= be_s;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (bus.dmem_resp) begin
                        state_r            <= DONE;
                        done_r             <= 1'b1;
                        count_r            <= '0;
                        dmem_read_r        <= 1'b0;
                        dmem_write_r       <= 1'b0;
                        dmem_address_r     <= 32'd0;
                        dmem_wdata_r       <= 32'd0;
                        dmem_byte_enable_r <= 4'd0;
                        if (dmem_read_r) begin
                            load_data_r <= extend_load(funct3_r, offset_r, bus.dmem_rdata);
                        end else begin
                            load_data_r <= load_data_r;
                        end
                    end else if (TIMEOUT_EN && (count_r == CNT_LAST)) begin
                        state_r            <= DONE;
                        done_r             <= 1'b1;
                        fault_r            <= 1'b1;
                        fault_cause_r      <= CAUSE_TIMEOUT;
                        count_r            <= '0;
                        dmem_read_r        <= 1'b0;
                        dmem_write_r       <= 1'b0;
                        dmem_address_r     <= 32'd0;
                        dmem_wdata_r       <= 32'd0;
                        dmem_byte_enable_r <= 4'd0;
                    end else begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_r       <= IDLE;
                    done_r        <= 1'b0;
                    fault_r       <= 1'b0;
                    fault_cause_r <= CAUSE_NONE;
                    count_r       <= '0;
                end
                default: begin
                    state_r            <= IDLE;
                    count_r            <= '0;
                    dmem_read_r        <= 1'b0;
                    dmem_write_r       <= 1'b0;
                    dmem_address_r     <= 32'd0;
                    dmem_wdata_r       <= 32'd0;
                    dmem_byte_enable_r <= 4'd0;
                    done_r             <= 1'b0;
                    fault_r            <= 1'b0;
                    fault_cause_r      <= CAUSE_NONE;
                end
            endcase
        end
    end

    // Stall must react in the acceptance cycle itself, so it combines state with the live request.
    assign bus.stall = ((state_r == IDLE) & req_s) | (state_r == ACCESS);

    assign bus.dmem_read        = dmem_read_r;
    assign bus.dmem_write       = dmem_write_r;
    assign bus.dmem_address     = dmem_address_r;
    assign bus.dmem_wdata       = dmem_wdata_r;
    assign bus.dmem_byte_enable = dmem_byte_enable_r;
    assign bus.done             = done_r;
    assign bus.load_data        = load_data_r;
    assign bus.fault            = fault_r;
    assign bus.fault_cause      = fault_cause_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed and randomized checks of mem_stage_lsu against an arithmetic reference model.
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    logic [31:0] exp_ld;

    mem_stage_lsu_if ifc ();

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request from the acceptance cycle through the idle cycle after done.
    // dly is the ACCESS cycle (1-based) that gets the response. Anything outside 1..TO never responds.
    task automatic txn(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                       input int dly);
        logic [1:0]  cause;
        int          sz;
        int          off;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] w;
        logic [31:0] mask;
        logic [31:0] ld;
        logic [31:0] r;
        int          k;
        bit          hit;
        off   = int'(a[1:0]);
        sz    = 1 << f3[1:0];
        cause = 2'b00;
        if (mr && mw) cause = 2'b11;
        else if (mr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) cause = 2'b11;
        else if (mw && f3 > 3'd2) cause = 2'b11;
        else if ((off % sz) != 0) cause = 2'b01;
        be   = mw ? 4'(((1 << sz) - 1) << off) : 4'hF;
        wd   = sd << (8 * off);
        w    = rd >> (8 * off);
        mask = (sz >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        ld   = w & mask;
        if (!f3[2] && sz < 4 && w[8 * sz - 1]) ld = ld | ~mask;

        ifc.req_valid  = 1'b1;
        ifc.mem_read   = mr;
        ifc.mem_write  = mw;
        ifc.funct3     = f3;
        ifc.addr       = a;
        ifc.store_data = sd;
        #1;
        check("accept_stall", 32'(ifc.stall), 32'd1);
        check("accept_done", 32'(ifc.done), 32'd0);
        @(negedge clk);
        r = $urandom;
        ifc.req_valid  = 1'b0;
        ifc.funct3     = r[2:0];
        ifc.addr       = $urandom;
        ifc.store_data = $urandom;

        if (cause != 2'b00) begin
            check("flt_done", 32'(ifc.done), 32'd1);
            check("flt_fault", 32'(ifc.fault), 32'd1);
            check("flt_cause", 32'(ifc.fault_cause), 32'(cause));
            check("flt_strobe", {30'd0, ifc.dmem_read, ifc.dmem_write}, 32'd0);
            check("flt_stall", 32'(ifc.stall), 32'd0);
            check("flt_ld", ifc.load_data, exp_ld);
        end else begin
            k   = 1;
            hit = 1'b0;
            while (!hit && k <= TO) begin
                check("acc_strobe", {30'd0, ifc.dmem_read, ifc.dmem_write}, {30'd0, mr, mw});
                check("acc_addr", ifc.dmem_address, {a[31:2], 2'b00});
                check("acc_be", 32'(ifc.dmem_byte_enable), 32'(be));
                if (mw) check("acc_wdata", ifc.dmem_wdata, wd);
                check("acc_stall", 32'(ifc.stall), 32'd1);
                check("acc_done", 32'(ifc.done), 32'd0);
                if (k == dly) begin
                    ifc.dmem_resp  = 1'b1;
                    ifc.dmem_rdata = rd;
                    hit = 1'b1;
                end
                @(negedge clk);
                ifc.dmem_resp  = 1'b0;
                ifc.dmem_rdata = $urandom;
                k++;
            end
            if (hit && mr) exp_ld = ld;
            check("fin_done", 32'(ifc.done), 32'd1);
            check("fin_fault", 32'(ifc.fault), hit ? 32'd0 : 32'd1);
            check("fin_cause", 32'(ifc.fault_cause), hit ? 32'd0 : 32'd2);
            check("fin_strobe", {30'd0, ifc.dmem_read, ifc.dmem_write}, 32'd0);
            check("fin_stall", 32'(ifc.stall), 32'd0);
            check("fin_ld", ifc.load_data, exp_ld);
        end
        @(negedge clk);
        check("post_done", 32'(ifc.done), 32'd0);
        check("post_fault", 32'(ifc.fault), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [2:0]  f3;
        logic        mr;
        logic        mw;
        tests = 0;
        fails = 0;
        exp_ld = 32'd0;
        rst_n = 1'b0;
        ifc.req_valid  = 1'b0;
        ifc.mem_read   = 1'b0;
        ifc.mem_write  = 1'b0;
        ifc.funct3     = 3'd0;
        ifc.addr       = 32'd0;
        ifc.store_data = 32'd0;
        ifc.dmem_resp  = 1'b0;
        ifc.dmem_rdata = 32'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_done", 32'(ifc.done), 32'd0);
        check("rst_fault", 32'(ifc.fault), 32'd0);
        check("rst_cause", 32'(ifc.fault_cause), 32'd0);
        check("rst_strobe", {30'd0, ifc.dmem_read, ifc.dmem_write}, 32'd0);
        check("rst_bus", ifc.dmem_address | ifc.dmem_wdata | 32'(ifc.dmem_byte_enable), 32'd0);
        check("rst_ld", ifc.load_data, 32'd0);
        check("rst_stall", 32'(ifc.stall), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        txn(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 3);
        check("lw_const", ifc.load_data, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_0000, 1);
        check("lb_const", ifc.load_data, 32'hFFFFFF80);
        txn(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_0000, 2);
        check("lbu_const", ifc.load_data, 32'h00000080);
        txn(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 32'h8001_0000, 1);
        check("lh_const", ifc.load_data, 32'hFFFF8001);
        txn(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 32'h8001_0000, 2);
        check("lhu_const", ifc.load_data, 32'h00008001);
        txn(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h12345678, 2);
        check("sb_keep_ld", ifc.load_data, 32'h00008001);
        txn(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000CDEF, 32'd0, 1);
        txn(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 1);
        txn(1'b1, 1'b1, 3'b010, 32'h100, 32'd0, 32'd0, 1);
        txn(1'b1, 1'b0, 3'b111, 32'h100, 32'd0, 32'd0, 1);
        txn(1'b0, 1'b1, 3'b011, 32'h100, 32'd0, 32'd0, 1);
        txn(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'h11111111, 0);
        txn(1'b1, 1'b0, 3'b010, 32'h304, 32'd0, 32'h22222222, TO);

        // Non-memory instruction: no stall and no done
        ifc.req_valid = 1'b1;
        ifc.mem_read  = 1'b0;
        ifc.mem_write = 1'b0;
        #1;
        check("nomem_stall", 32'(ifc.stall), 32'd0);
        @(negedge clk);
        check("nomem_done", 32'(ifc.done), 32'd0);
        ifc.req_valid = 1'b0;

        // A stray response in IDLE is ignored
        ifc.dmem_resp  = 1'b1;
        ifc.dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        ifc.dmem_resp = 1'b0;
        check("stray_done", 32'(ifc.done), 32'd0);
        check("stray_strobe", {30'd0, ifc.dmem_read, ifc.dmem_write}, 32'd0);
        @(negedge clk);
        check("stray_done2", 32'(ifc.done), 32'd0);
        check("stray_ld", ifc.load_data, exp_ld);

        // Reset asserted in the middle of an access, then a late response arrives
        ifc.req_valid = 1'b1;
        ifc.mem_read  = 1'b1;
        ifc.mem_write = 1'b0;
        ifc.funct3    = 3'b010;
        ifc.addr      = 32'h400;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        @(negedge clk);
        check("mid_strobe_pre", 32'(ifc.dmem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_strobe_rst", {30'd0, ifc.dmem_read, ifc.dmem_write}, 32'd0);
        check("mid_stall_rst", 32'(ifc.stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ld = 32'd0;
        ifc.dmem_resp  = 1'b1;
        ifc.dmem_rdata = 32'h55AA55AA;
        @(negedge clk);
        ifc.dmem_resp = 1'b0;
        check("late_done", 32'(ifc.done), 32'd0);
        check("late_strobe", {30'd0, ifc.dmem_read, ifc.dmem_write}, 32'd0);
        @(negedge clk);
        check("late_done2", 32'(ifc.done), 32'd0);
        check("late_ld", ifc.load_data, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            r = $urandom;
            mr = 1'b0;
            mw = 1'b0;
            case (r[3:0] % 4'd10)
                4'd0:                            begin mr = 1'b1; mw = 1'b1; end
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5:    mr = 1'b1;
                default:                         mw = 1'b1;
            endcase
            if (r[5:4] == 2'b00) begin
                f3 = r[8:6];
            end else if (mr) begin
                case (r[10:8] % 3'd5)
                    3'd0:    f3 = 3'b000;
                    3'd1:    f3 = 3'b001;
                    3'd2:    f3 = 3'b010;
                    3'd3:    f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'(r[10:8] % 3'd3);
            end
            txn(mr, mw, f3, $urandom, $urandom, $urandom, int'($urandom_range(1, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
